// File: rtl/sccb_config_sequencer.sv
// Camera register configuration sequencer: walks a {reg_addr,reg_data} table and issues one
// 3-phase SCCB write per entry through a byte-level master, with delays, NACK retry and handshake.
module sccb_config_sequencer #(
   parameter int         NUM_REGS    = 4,
   parameter logic [7:0] SLAVE_ADDR  = 8'h42,
   parameter int         POWERUP_CYC = 67_108_864,
   parameter int         GAP_CYC     = 65_536,
   parameter int         RESET_CYC   = 67_108_864,
   parameter int         MAX_RETRY   = 3,
   parameter int         CNT_W       = 28
) (
   input  logic        clk_100MHz,
   input  logic        rst,
   input  logic        go,
   output logic [7:0]  tbl_idx,
   input  logic [15:0] tbl_word,
   output logic        sccb_start,
   output logic        sccb_stop,
   output logic [7:0]  sccb_wr_data,
   input  logic [1:0]  sccb_ack,
   input  logic        sccb_idle,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  retry_total
);

   typedef enum logic [3:0] {
      S_IDLE, S_PWRUP, S_START, S_ADDR, S_DATA, S_FIN, S_GAP, S_DONE, S_FAIL
   } state_t;

   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYC - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       retries;
   logic             reset_gap;
   logic             ack_ok, ack_nack, retry_ok, delay_done, last_entry;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign ack_ok     = (sccb_ack == 2'b11);
   assign ack_nack   = (sccb_ack == 2'b10);
   assign retry_ok   = (int'(retries) < MAX_RETRY);
   assign last_entry = (tbl_idx == 8'(NUM_REGS));
   // One counter serves both delays; a soft-reset write (0x12_80) gets the long gap.
   assign delay_done = (state == S_PWRUP) ? (cnt == PWR_LAST)
                                          : (cnt == (reset_gap ? RST_LAST : GAP_LAST));

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_FAIL: if (go) state_nxt = S_PWRUP;
         S_PWRUP: if (delay_done) state_nxt = S_START;
         S_START: if (sccb_idle) state_nxt = S_ADDR;
         S_ADDR: begin
            if (ack_ok)        state_nxt = S_DATA;
            else if (ack_nack) state_nxt = retry_ok ? S_GAP : S_FAIL;
         end
         S_DATA: begin
            if (ack_ok)        state_nxt = S_FIN;
            else if (ack_nack) state_nxt = retry_ok ? S_GAP : S_FAIL;
         end
         S_FIN: begin
            if (ack_ok)        state_nxt = S_GAP;
            else if (ack_nack) state_nxt = retry_ok ? S_GAP : S_FAIL;
         end
         S_GAP: if (delay_done) state_nxt = last_entry ? S_DONE : S_START;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Master strobes and byte are decoded in the same cycle as the ack tick.
   always_comb begin
      sccb_start   = 1'b0;
      sccb_stop    = 1'b0;
      sccb_wr_data = 8'h00;
      case (state)
         S_START: if (sccb_idle) begin
            sccb_start   = 1'b1;
            sccb_wr_data = SLAVE_ADDR;
         end
         S_ADDR: begin
            if (ack_ok)        sccb_wr_data = tbl_word[15:8];
            else if (ack_nack) sccb_stop    = 1'b1;
         end
         S_DATA: begin
            if (ack_ok)        sccb_wr_data = tbl_word[7:0];
            else if (ack_nack) sccb_stop    = 1'b1;
         end
         S_FIN: if (ack_ok || ack_nack) sccb_stop = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         retries     <= '0;
         reset_gap   <= 1'b0;
         tbl_idx     <= 8'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         retry_total <= 8'd0;
      end else begin
         if (state_nxt != state)
            cnt <= '0;
         else if (state == S_PWRUP || state == S_GAP)
            cnt <= cnt + CNT_W'(1);

         case (state)
            S_IDLE, S_DONE, S_FAIL: if (go) begin
               done        <= 1'b0;
               error       <= 1'b0;
               retry_total <= 8'd0;
               tbl_idx     <= 8'd0;
               busy        <= 1'b1;
               retries     <= '0;
               reset_gap   <= 1'b0;
            end
            S_ADDR, S_DATA, S_FIN: begin
               if (ack_nack) begin
                  retry_total <= sat_inc8(retry_total);
                  reset_gap   <= 1'b0;
                  if (retry_ok) begin
                     retries <= retries + 4'd1;
                  end else begin
                     error <= 1'b1;
                     busy  <= 1'b0;
                  end
               end else if (ack_ok && state == S_FIN) begin
                  retries   <= '0;
                  tbl_idx   <= tbl_idx + 8'd1;
                  reset_gap <= (tbl_word == 16'h1280);
               end
            end
            S_GAP: if (delay_done && last_entry) begin
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sccb_config_sequencer.sv
// Bench for sccb_config_sequencer: a byte-level SCCB master model logs the byte/stop stream,
// a scenario table sets NACK patterns and expected results, plus reset and timing sequences.
module tb_sccb_config_sequencer;

   localparam int STP = 256;

   logic        clk, rst, go;
   logic [7:0]  tbl_idx;
   logic [15:0] tbl_word;
   logic        sccb_start, sccb_stop;
   logic [7:0]  sccb_wr_data;
   logic [1:0]  sccb_ack;
   logic        sccb_idle;
   logic        busy, done, error;
   logic [7:0]  retry_total;

   sccb_config_sequencer #(
      .NUM_REGS(2), .SLAVE_ADDR(8'h42), .POWERUP_CYC(10), .GAP_CYC(5),
      .RESET_CYC(20), .MAX_RETRY(3), .CNT_W(8)
   ) dut (
      .clk_100MHz(clk), .rst(rst), .go(go), .tbl_idx(tbl_idx), .tbl_word(tbl_word),
      .sccb_start(sccb_start), .sccb_stop(sccb_stop), .sccb_wr_data(sccb_wr_data),
      .sccb_ack(sccb_ack), .sccb_idle(sccb_idle), .busy(busy), .done(done),
      .error(error), .retry_total(retry_total)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      case (tbl_idx)
         8'd0:    tbl_word = 16'h1280;
         8'd1:    tbl_word = 16'h8C02;
         default: tbl_word = 16'h0000;
      endcase
   end

   int checks, errors;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Master model: ack tick 3 cycles after each byte, bus not idle until 2 cycles after STOP.
   int log_q[$];
   int start_cyc[$];
   int stop_cyc[$];
   int attempt, nack_att, nack_byte;
   int tmr, stmr, bno;
   bit mbusy;

   initial begin
      sccb_ack  = 2'b00;
      sccb_idle = 1'b1;
      tmr = 0; stmr = 0; bno = 0; mbusy = 1'b0;
      forever begin
         @(negedge clk);
         sccb_ack = 2'b00;
         if (tmr > 0) begin
            tmr--;
            if (tmr == 0)
               sccb_ack = (attempt <= nack_att && bno == nack_byte) ? 2'b10 : 2'b11;
         end
         if (stmr > 0) stmr--;
         sccb_idle = !mbusy && stmr == 0;
         #1;
         if (rst) begin
            tmr = 0; stmr = 0; mbusy = 1'b0;
         end else begin
            if (sccb_start) begin
               log_q.push_back(int'(sccb_wr_data));
               start_cyc.push_back(cyc);
               mbusy = 1'b1; bno = 0; attempt++; tmr = 3;
            end
            if (sccb_ack == 2'b11 && bno < 2) begin
               log_q.push_back(int'(sccb_wr_data));
               bno++; tmr = 3;
            end
            if (sccb_stop) begin
               log_q.push_back(STP);
               stop_cyc.push_back(cyc);
               mbusy = 1'b0; stmr = 2; tmr = 0;
            end
         end
      end
   end

   typedef struct {
      int nack_att;
      int nack_byte;
      bit extra_go;
      int exp_first;
      int exp_len;
      bit exp_done;
      bit exp_err;
      int exp_retry;
      int exp_idx;
   } vec_t;

   vec_t vecs[5];
   int   exp_stream[$];

   function automatic int count_stops();
      int c = 0;
      foreach (log_q[i]) if (log_q[i] == STP) c++;
      return c;
   endfunction

   task automatic run_vec(input int k, input vec_t v);
      int n, go_cyc, act;
      log_q.delete(); start_cyc.delete(); stop_cyc.delete();
      attempt = 0; nack_att = v.nack_att; nack_byte = v.nack_byte;
      @(negedge clk);
      go = 1'b1; go_cyc = cyc;
      @(negedge clk);
      go = 1'b0;
      #2;
      check($sformatf("v%0d busy after go", k), busy, 1);
      check($sformatf("v%0d done cleared", k), done, 0);
      check($sformatf("v%0d error cleared", k), error, 0);
      check($sformatf("v%0d retry cleared", k), retry_total, 0);
      if (v.extra_go) begin
         repeat (2) @(negedge clk);
         go = 1'b1;
         @(negedge clk);
         go = 1'b0;
      end
      n = 0;
      while (busy === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      #2;
      check($sformatf("v%0d finished in budget", k), n < 3000, 1);
      check($sformatf("v%0d done", k), done, v.exp_done);
      check($sformatf("v%0d error", k), error, v.exp_err);
      check($sformatf("v%0d retry_total", k), retry_total, v.exp_retry);
      check($sformatf("v%0d tbl_idx", k), tbl_idx, v.exp_idx);
      check($sformatf("v%0d stream length", k), log_q.size(), v.exp_len);
      for (int i = 0; i < v.exp_len; i++) begin
         act = (i < log_q.size()) ? log_q[i] : -1;
         check($sformatf("v%0d item %0d", k, i), act, exp_stream[v.exp_first + i]);
      end
      if (k == 0) begin
         check("v0 powerup to first start", (start_cyc.size() > 0) ? start_cyc[0] - go_cyc : -1, 11);
         check("v0 reset gap stop to start",
               (start_cyc.size() > 1 && stop_cyc.size() > 0) ? start_cyc[1] - stop_cyc[0] : -1, 21);
      end
      if (k == 1)
         check("v1 retry gap stop to start",
               (start_cyc.size() > 1 && stop_cyc.size() > 0) ? start_cyc[1] - stop_cyc[0] : -1, 6);
      if (v.exp_err) begin
         repeat (40) @(negedge clk);
         #2;
         check($sformatf("v%0d no start after error", k), start_cyc.size(), 4);
         check($sformatf("v%0d error held", k), error, 1);
      end
   endtask

   initial begin
      int n;
      checks = 0; errors = 0;
      rst = 1'b1; go = 1'b0; nack_att = 0; nack_byte = 0; attempt = 0;

      exp_stream = {'h42, 'h12, 'h80, STP, 'h42, 'h8C, 'h02, STP,
                    'h42, STP, 'h42, STP, 'h42, 'h12, 'h80, STP, 'h42, 'h8C, 'h02, STP,
                    'h42, STP, 'h42, STP, 'h42, STP, 'h42, STP,
                    'h42, 'h12, 'h80, STP, 'h42, 'h12, 'h80, STP, 'h42, 'h8C, 'h02, STP,
                    'h42, 'h12, STP, 'h42, 'h12, 'h80, STP, 'h42, 'h8C, 'h02, STP};
      vecs[0] = '{nack_att: 0,  nack_byte: 0, extra_go: 1'b1, exp_first: 0,  exp_len: 8,
                  exp_done: 1'b1, exp_err: 1'b0, exp_retry: 0, exp_idx: 2};
      vecs[1] = '{nack_att: 2,  nack_byte: 0, extra_go: 1'b0, exp_first: 8,  exp_len: 12,
                  exp_done: 1'b1, exp_err: 1'b0, exp_retry: 2, exp_idx: 2};
      vecs[2] = '{nack_att: 99, nack_byte: 0, extra_go: 1'b0, exp_first: 20, exp_len: 8,
                  exp_done: 1'b0, exp_err: 1'b1, exp_retry: 4, exp_idx: 0};
      vecs[3] = '{nack_att: 1,  nack_byte: 2, extra_go: 1'b0, exp_first: 28, exp_len: 12,
                  exp_done: 1'b1, exp_err: 1'b0, exp_retry: 1, exp_idx: 2};
      vecs[4] = '{nack_att: 1,  nack_byte: 1, extra_go: 1'b0, exp_first: 40, exp_len: 11,
                  exp_done: 1'b1, exp_err: 1'b0, exp_retry: 1, exp_idx: 2};

      repeat (3) @(negedge clk);
      #2;
      check("reset tbl_idx", tbl_idx, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset error", error, 0);
      check("reset retry_total", retry_total, 0);
      check("reset sccb_start", sccb_start, 0);
      check("reset sccb_stop", sccb_stop, 0);
      check("reset sccb_wr_data", sccb_wr_data, 0);
      @(negedge clk);
      rst = 1'b0;

      // Reset while the data byte is pending: outputs clear at once, no STOP issued.
      log_q.delete(); start_cyc.delete(); stop_cyc.delete(); attempt = 0;
      @(negedge clk); go = 1'b1;
      @(negedge clk); go = 1'b0;
      n = 0;
      while (log_q.size() < 2 && n < 200) begin
         @(posedge clk);
         n++;
      end
      check("rst-in-data reached DATA", n < 200, 1);
      @(negedge clk);
      check("rst-in-data busy before", busy, 1);
      rst = 1'b1;
      #2;
      check("rst-in-data tbl_idx", tbl_idx, 0);
      check("rst-in-data busy", busy, 0);
      check("rst-in-data done", done, 0);
      check("rst-in-data error", error, 0);
      check("rst-in-data retry_total", retry_total, 0);
      check("rst-in-data sccb_start", sccb_start, 0);
      check("rst-in-data sccb_stop", sccb_stop, 0);
      check("rst-in-data sccb_wr_data", sccb_wr_data, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      #2;
      check("rst-in-data no stop", count_stops(), 0);
      check("rst-in-data stays idle", start_cyc.size(), 1);

      for (int k = 0; k < 5; k++) run_vec(k, vecs[k]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
